// File: rtl/pad_loopback_if.sv
// Pad loopback tester bus: control, status and pad-side nets.
// The master side is the controller (and the pad model); the slave is the tester.
interface pad_loopback_if #(
  parameter int ERR_W = 8
) ();
  logic             start;
  logic             pattern_sel;
  logic             pad_a;
  logic             pad_oe;
  logic             pad_ie;
  logic             pad_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;

  modport master (
    output start, pattern_sel, pad_y,
    input  pad_a, pad_oe, pad_ie, busy, done, pass, err_count
  );

  modport slave (
    input  start, pattern_sel, pad_y,
    output pad_a, pad_oe, pad_ie, busy, done, pass, err_count
  );
endinterface

// File: rtl/pad_loopback_tester.sv
// Pad loopback self-test: drives a PRBS8 or alternating pattern onto the test
// pad, reads it back through a 2-flop synchroniser and counts mismatches.
module pad_loopback_tester #(
  parameter int PATTERN_LEN   = 64,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pad_loopback_if.slave   bus
);
  localparam int BW = $clog2(PATTERN_LEN + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [7:0]       SEED    = 8'h01;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             sync1, sync2;
  logic             sel_q;
  logic             a_q, oe_q, ie_q, busy_q, done_q, pass_q;
  logic [7:0]       lfsr, lfsr_nxt;
  logic [BW-1:0]    bit_cnt;
  logic [SW-1:0]    settle;
  logic [ERR_W-1:0] err_q, err_nxt;
  logic             sample, last_bit;

  // Pattern step, sample strobe and saturating error update. a_q always holds
  // the expected bit while running, so it doubles as the comparator reference.
  always_comb begin
    lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    sample   = (settle == SW'(SETTLE_CYCLES));
    last_bit = (bit_cnt == BW'(PATTERN_LEN - 1));
    err_nxt  = err_q;
    if (sample && (sync2 != a_q) && (err_q != ERR_MAX))
      err_nxt = err_q + ERR_W'(1);
  end

  // Two-flop synchroniser for the asynchronous pad readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.pad_y;
      sync2 <= sync1;
    end
  end

  // Run control FSM with registered pad and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_q   <= 1'b0;
      lfsr    <= SEED;
      bit_cnt <= '0;
      settle  <= '0;
      err_q   <= '0;
      a_q     <= 1'b0;
      oe_q    <= 1'b0;
      ie_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      ie_q <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= RUN;
            sel_q   <= bus.pattern_sel;
            lfsr    <= SEED;
            bit_cnt <= '0;
            settle  <= '0;
            err_q   <= '0;
            // first bit: alternating starts at 1, PRBS starts at seed MSB
            a_q     <= bus.pattern_sel ? 1'b1 : SEED[7];
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        RUN: begin
          if (sample) begin
            err_q   <= err_nxt;
            lfsr    <= lfsr_nxt;
            bit_cnt <= bit_cnt + BW'(1);
            settle  <= '0;
            if (last_bit) begin
              state  <= DONE;
              a_q    <= 1'b0;
              oe_q   <= 1'b0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (err_nxt == '0);
            end else begin
              // next bit: alternating is ~(k+1)[0] = k[0]; PRBS is lfsr_nxt[7]
              a_q <= sel_q ? bit_cnt[0] : lfsr[6];
            end
          end else begin
            settle <= settle + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pad_a     = a_q;
  assign bus.pad_oe    = oe_q;
  assign bus.pad_ie    = ie_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_pad_loopback_tester.sv
// Bench for pad_loopback_tester: table-driven directed runs, randomized runs
// against a pattern-level reference model, plus reset/relaunch/saturation cases.
module tb_pad_loopback_tester;
  localparam int L   = 64;
  localparam int S   = 4;
  localparam int TOT = L * (S + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pad_loopback_if #(.ERR_W(8)) bus ();
  pad_loopback_if #(.ERR_W(4)) bus4 ();

  pad_loopback_tester #(.PATTERN_LEN(L), .SETTLE_CYCLES(S), .ERR_W(8))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pad_loopback_tester #(.PATTERN_LEN(L), .SETTLE_CYCLES(S), .ERR_W(4))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int n_cmp = 0;
  int n_bad = 0;
  bit prbs [L];

  // mode: 0 ideal loopback, 1 stuck 0, 2 stuck 1, 3 inverted, 4 random per bit
  typedef struct {
    bit sel;
    int mode;
    bit wiggle;
    int exp_err;
    bit exp_pass;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic bit exp_bit(input bit sel, input int k);
    return sel ? (k % 2 == 0) : prbs[k];
  endfunction

  // One full run from IDLE/DONE; exp_err < 0 means use the reference model.
  task automatic run(input bit sel, input int mode, input bit wiggle,
                     input int exp_err, input bit exp_pass);
    bit ybits [L];
    int model, e, abad, wbad, k;
    bit p, a, y;
    logic [7:0] cap;
    model = 0; abad = 0; wbad = 0; cap = '0;
    for (int i = 0; i < L; i++) begin
      ybits[i] = 1'($urandom_range(0, 1));
      case (mode)
        0:       y = exp_bit(sel, i);
        1:       y = 1'b0;
        2:       y = 1'b1;
        3:       y = ~exp_bit(sel, i);
        default: y = ybits[i];
      endcase
      if (y != exp_bit(sel, i)) model++;
    end
    if (model > 255) model = 255;
    e = (exp_err < 0) ? model : exp_err;
    p = (exp_err < 0) ? (model == 0) : exp_pass;

    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern_sel = sel;
    @(posedge clk); #1;
    chk("launch_busy", bus.busy, 1);
    chk("launch_done_low", bus.done, 0);
    for (int c = 0; c < TOT; c++) begin
      @(negedge clk);
      if (c == 0 || c >= TOT - 2) bus.start = 1'b0;
      else if (wiggle) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.pattern_sel = 1'($urandom_range(0, 1));
      end
      k = c / (S + 1);
      a = bus.pad_a;
      if (a !== exp_bit(sel, k)) abad++;
      if ((c % (S + 1) == 0) && k < 8) cap[k] = a;
      if (bus.pad_oe !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) wbad++;
      case (mode)
        0:       bus.pad_y = a;
        1:       bus.pad_y = 1'b0;
        2:       bus.pad_y = 1'b1;
        3:       bus.pad_y = ~a;
        default: bus.pad_y = ybits[k];
      endcase
      @(posedge clk);
    end
    #1;
    chk("done_rise", bus.done, 1);
    chk("busy_end", bus.busy, 0);
    chk("oe_end", bus.pad_oe, 0);
    chk("a_end", bus.pad_a, 0);
    chk("err_count", bus.err_count, e);
    chk("pass", bus.pass, p);
    chk("pad_a_seq_bad", abad, 0);
    chk("run_window_bad", wbad, 0);
    if (!sel) chk("prbs_first8", cap, 8'h80);
  endtask

  initial begin : main
    logic [7:0] l;
    int cyc, sat_exp;
    bus.start = 1'b0; bus.pattern_sel = 1'b0; bus.pad_y = 1'b0;
    bus4.start = 1'b0; bus4.pattern_sel = 1'b0; bus4.pad_y = 1'b1;

    l = 8'h01;
    for (int k = 0; k < L; k++) begin
      prbs[k] = l[7];
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end

    tbl[0] = '{sel: 1'b0, mode: 0, wiggle: 1'b0, exp_err: 0,  exp_pass: 1'b1};
    tbl[1] = '{sel: 1'b1, mode: 0, wiggle: 1'b0, exp_err: 0,  exp_pass: 1'b1};
    tbl[2] = '{sel: 1'b1, mode: 1, wiggle: 1'b0, exp_err: 32, exp_pass: 1'b0};
    tbl[3] = '{sel: 1'b1, mode: 2, wiggle: 1'b0, exp_err: 32, exp_pass: 1'b0};
    tbl[4] = '{sel: 1'b0, mode: 3, wiggle: 1'b1, exp_err: 64, exp_pass: 1'b0};
    tbl[5] = '{sel: 1'b1, mode: 3, wiggle: 1'b0, exp_err: 64, exp_pass: 1'b0};

    // reset state, then pad_ie rises on the first edge after release
    #2;
    chk("reset_outputs", {bus.pad_a, bus.pad_oe, bus.pad_ie, bus.busy, bus.done,
                          bus.pass, bus.err_count}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ie_before_edge", bus.pad_ie, 0);
    @(posedge clk); #1;
    chk("ie_after_edge", bus.pad_ie, 1);
    chk("idle_oe", bus.pad_oe, 0);

    foreach (tbl[i]) run(tbl[i].sel, tbl[i].mode, tbl[i].wiggle, tbl[i].exp_err, tbl[i].exp_pass);

    for (int r = 0; r < 6; r++)
      run(1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1, 1'b0);

    // start held high: back-to-back runs, done lasts one cycle, err cleared
    @(negedge clk);
    bus.start = 1'b1; bus.pattern_sel = 1'b1; bus.pad_y = 1'b0;
    @(posedge clk); #1;
    cyc = 400;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin cyc = i; break; end
    end
    chk("b2b_first_cycles", cyc, TOT);
    chk("b2b_first_err", bus.err_count, 32);
    @(posedge clk); #1;
    chk("b2b_done_one_cycle", bus.done, 0);
    chk("b2b_relaunch_busy", bus.busy, 1);
    chk("b2b_err_cleared", bus.err_count, 0);
    cyc = 400;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin cyc = i; break; end
    end
    chk("b2b_second_cycles", cyc, TOT);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_holds", {bus.done, bus.busy, bus.err_count}, {1'b1, 1'b0, 8'd32});

    // reset 100 cycles into an inverted PRBS run
    @(negedge clk);
    bus.start = 1'b1; bus.pattern_sel = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.pad_y = ~bus.pad_a;
    end
    chk("err_pre_reset", bus.err_count, 19);
    rst_n = 1'b0;
    #1;
    chk("reset_midrun", {bus.pad_oe, bus.busy, bus.err_count, bus.pad_a,
                         bus.done, bus.pad_ie}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ie_low_after_release", bus.pad_ie, 0);
    @(posedge clk); #1;
    chk("ie_back", bus.pad_ie, 1);
    chk("idle_after_reset", {bus.busy, bus.done, bus.pad_oe}, 0);

    // saturation on the 4-bit counter instance with pad_y tied 1
    sat_exp = 0;
    for (int k = 0; k < L; k++) if (prbs[k] == 1'b0) sat_exp++;
    if (sat_exp > 15) sat_exp = 15;
    @(negedge clk);
    bus4.start = 1'b1; bus4.pattern_sel = 1'b0;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    cyc = 400;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (bus4.done) begin cyc = i; break; end
    end
    chk("sat_cycles", cyc, TOT);
    chk("sat_err", bus4.err_count, sat_exp);
    chk("sat_pass", bus4.pass, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pad_loopback_tester.md
Name:
pad_loopback_tester

Overview:
- Self-test engine for the chip-level test pad group.
- Drives a known bit pattern onto the test pad output (A) with its output enable (OE) asserted.
- Reads the pad input (Y) back through a 2-flop synchroniser and counts mismatches.
- Sits directly upstream of the pad wiring block: its pad_a, pad_oe and pad_ie outputs feed the ta/toe/tie pad nets, and it consumes ty.

Parameters:
- PATTERN_LEN, 64, number of bits driven and checked per test run (1..1023).
- SETTLE_CYCLES, 4, cycles each bit is held before sampling; must be >=3 to cover the synchroniser plus pad delay.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled in IDLE or DONE to launch a run.
- pattern_sel  input  1  0 = PRBS8, 1 = alternating 1,0,1,0...; sampled with start.
- pad_a  output  1  data driven to the test pad.
- pad_oe  output  1  pad output enable.
- pad_ie  output  1  pad input enable; constant 1 after reset.
- pad_y  input  1  asynchronous pad readback.
- busy  output  1  high while a run is in progress.
- done  output  1  high in DONE state.
- pass  output  1  valid when done=1; 1 when err_count == 0.
- err_count  output  ERR_W  mismatch count; saturating.

Behaviour:
- Reset (asynchronous, active-low) values:
  - pad_a=0, pad_oe=0, pad_ie=0, busy=0, done=0, pass=0, err_count=0.
  - Synchroniser flops=0, LFSR=8'h01, bit and settle counters=0, state=IDLE.
- pad_ie goes to 1 on the first clock after reset release and stays 1.
- PRBS8 generator:
  - Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'h01.
  - Output bit = lfsr[7].
  - Next state = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Alternating pattern: bit k = ~k[0], so the first bit is 1.
- State machine: IDLE -> RUN -> DONE -> (RUN | IDLE).
- IDLE:
  - pad_oe=0, pad_a=0.
  - On a clock edge with start=1: latch pattern_sel, clear err_count, reset LFSR to seed and counters to 0, go to RUN.
- RUN:
  - busy=1, pad_oe=1.
  - pad_a presents expected bit k from the first RUN cycle.
  - Settle counter counts 0..SETTLE_CYCLES, one step per cycle.
  - In the cycle the count equals SETTLE_CYCLES:
    - Compare the synchronised y (second flop) with expected bit k.
    - On mismatch, increment err_count, saturating at 2^ERR_W-1.
    - Advance the pattern and bit counter; clear the settle counter.
  - Each bit therefore occupies SETTLE_CYCLES+1 cycles.
  - After bit PATTERN_LEN-1 is compared, go to DONE.
- Timing: if start is sampled at edge N, done rises at edge N + PATTERN_LEN*(SETTLE_CYCLES+1). With defaults this is N+320.
- DONE:
  - busy=0, done=1, pad_oe=0, pad_a=0.
  - pass = (err_count==0); err_count is held.
  - start=1 at an edge: relaunch exactly as from IDLE, with done dropping at that edge.
  - start=0: remain in DONE. There is no return to IDLE except by reset.
- start while RUN is ignored.
- pattern_sel changes during RUN are ignored.
- pad_y is never used combinationally. Only the second synchroniser flop feeds the comparator.
- Reset asserted mid-run: all outputs return immediately to their reset values. pad_oe=0 is required asynchronously so the pad is released.
- Saturation: err_count stays at its maximum and pass=0.

Test Plan:
- Ideal loopback (pad_y = pad_a delayed 1 cycle), pattern_sel=0, start pulsed at edge 10 -> busy=1 from edge 10, done=1 at edge 330, err_count=0, pass=1; first 8 pad_a bits 0,0,0,0,0,0,0,1.
- pad_y tied 0, pattern_sel=1 -> err_count=32 (all 1-bits), pass=0, done at start+320.
- pad_y tied 1, PRBS, with ERR_W overridden to 4 -> err_count saturates at 15, pass=0.
- Reset asserted 100 cycles into a run -> pad_oe, busy, err_count all 0 within the same cycle; after release, the FSM is in IDLE and pad_ie returns to 1 one cycle later.
- start held high continuously -> runs back-to-back; done is high exactly one cycle at each run end; err_count is cleared at each relaunch.
- Loopback inverted (pad_y = ~pad_a delayed), PRBS -> err_count=64, pass=0; toggling start and pattern_sel mid-run has no effect on the run.
